// File: rtl/id_stage_pipe.sv
// Registered OpenMIPS decode stage: logic-immediate, LUI and R-type logic ops,
// EX/MEM operand forwarding, load-use stall, valid/ready ID/EX register.
// Build option: define ID_MEM_FWD_EN to enable forwarding from the MEM stage.
module id_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        inst_i,
    output logic               reg1_re,
    output logic               reg2_re,
    output logic [RADDR_W-1:0] reg1_addr,
    output logic [RADDR_W-1:0] reg2_addr,
    input  logic [DATA_W-1:0]  reg1_rdata,
    input  logic [DATA_W-1:0]  reg2_rdata,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic               ex_is_load_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         aluop_o,
    output logic [2:0]         alusel_o,
    output logic [DATA_W-1:0]  reg1_o,
    output logic [DATA_W-1:0]  reg2_o,
    output logic [RADDR_W-1:0] wd_o,
    output logic               wreg_o,
    output logic [31:0]        pc_o,
    output logic               inst_invalid_o,
    output logic               stall_req_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam logic [7:0] EXE_NOP_OP    = 8'h00;
    localparam logic [7:0] EXE_AND_OP    = 8'h24;
    localparam logic [7:0] EXE_OR_OP     = 8'h25;
    localparam logic [7:0] EXE_XOR_OP    = 8'h26;
    localparam logic [7:0] EXE_NOR_OP    = 8'h27;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;

    logic [5:0]         w_op;
    logic [5:0]         w_funct;
    logic [4:0]         w_sa;
    logic [RADDR_W-1:0] w_rs;
    logic [RADDR_W-1:0] w_rt;
    logic [RADDR_W-1:0] w_rd;
    logic [DATA_W-1:0]  w_zimm;

    assign w_op    = inst_i[31:26];
    assign w_funct = inst_i[5:0];
    assign w_sa    = inst_i[10:6];
    assign w_rs    = RADDR_W'(inst_i[25:21]);
    assign w_rt    = RADDR_W'(inst_i[20:16]);
    assign w_rd    = RADDR_W'(inst_i[15:11]);
    assign w_zimm  = DATA_W'(inst_i[15:0]);

    logic               w_re1;
    logic               w_re2;
    logic [7:0]         w_aluop;
    logic [2:0]         w_alusel;
    logic [RADDR_W-1:0] w_wd;
    logic               w_wreg;
    logic               w_inv;
    logic [DATA_W-1:0]  w_imm;

    // Instruction decode; anything unrecognised becomes an invalid NOP.
    always_comb begin
        w_re1    = 1'b0;
        w_re2    = 1'b0;
        w_aluop  = EXE_NOP_OP;
        w_alusel = EXE_RES_NOP;
        w_wd     = w_rt;
        w_wreg   = 1'b0;
        w_inv    = 1'b1;
        w_imm    = '0;
        unique case (1'b1)
            (w_op == 6'b001100),
            (w_op == 6'b001101),
            (w_op == 6'b001110): begin
                w_re1    = 1'b1;
                w_alusel = EXE_RES_LOGIC;
                w_wreg   = 1'b1;
                w_inv    = 1'b0;
                w_imm    = w_zimm;
                if (w_op == 6'b001100)
                    w_aluop = EXE_AND_OP;
                else if (w_op == 6'b001101)
                    w_aluop = EXE_OR_OP;
                else
                    w_aluop = EXE_XOR_OP;
            end
            (w_op == 6'b001111): begin
                w_aluop  = EXE_OR_OP;
                w_alusel = EXE_RES_LOGIC;
                w_wreg   = 1'b1;
                w_inv    = 1'b0;
                w_imm    = w_zimm << 16;
            end
            (w_op == 6'b000000 && w_sa == 5'd0
             && w_funct[5:2] == 4'b1001): begin
                w_re1    = 1'b1;
                w_re2    = 1'b1;
                w_alusel = EXE_RES_LOGIC;
                w_wd     = w_rd;
                w_wreg   = 1'b1;
                w_inv    = 1'b0;
                unique case (w_funct[1:0])
                    2'b00:   w_aluop = EXE_AND_OP;
                    2'b01:   w_aluop = EXE_OR_OP;
                    2'b10:   w_aluop = EXE_XOR_OP;
                    default: w_aluop = EXE_NOR_OP;
                endcase
            end
            default: ;
        endcase
    end

    logic w_ex_hit1;
    logic w_ex_hit2;
    logic w_mem_hit1;
    logic w_mem_hit2;

    assign w_ex_hit1 = ex_wreg_i & (ex_wd_i == w_rs);
    assign w_ex_hit2 = ex_wreg_i & (ex_wd_i == w_rt);
`ifdef ID_MEM_FWD_EN
    assign w_mem_hit1 = mem_wreg_i & (mem_wd_i == w_rs);
    assign w_mem_hit2 = mem_wreg_i & (mem_wd_i == w_rt);
`else
    logic w_mem_unused;
    assign w_mem_hit1   = 1'b0;
    assign w_mem_hit2   = 1'b0;
    assign w_mem_unused = mem_wreg_i ^ (^mem_wd_i);
`endif

    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    // Operand select: r0, then EX, then MEM, then register file.
    always_comb begin
        w_op1 = reg1_rdata;
        w_op2 = reg2_rdata;
        if (w_rs == '0)
            w_op1 = '0;
        else if (w_ex_hit1)
            w_op1 = ex_wdata_i;
        else if (w_mem_hit1)
            w_op1 = mem_wdata_i;
        if (w_rt == '0)
            w_op2 = '0;
        else if (w_ex_hit2)
            w_op2 = ex_wdata_i;
        else if (w_mem_hit2)
            w_op2 = mem_wdata_i;
        if (!w_re1)
            w_op1 = '0;
        if (!w_re2)
            w_op2 = w_imm;
    end

    logic w_ex_ld;
    logic w_stall;
    logic w_accept;
    logic r_valid;

    assign w_ex_ld  = ex_is_load_i & ex_wreg_i & (ex_wd_i != '0);
    assign w_stall  = in_valid & w_ex_ld
                    & ((w_re1 & (ex_wd_i == w_rs))
                     | (w_re2 & (ex_wd_i == w_rt)));
    assign in_ready = !w_stall & !flush_i & (!r_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    assign reg1_re     = w_re1;
    assign reg2_re     = w_re2;
    assign reg1_addr   = w_rs;
    assign reg2_addr   = w_rt;
    assign stall_req_o = w_stall;
    assign out_valid   = r_valid;

    // ID/EX register: flush beats accept; consume without accept leaves a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= 1'b0;
            aluop_o        <= EXE_NOP_OP;
            alusel_o       <= EXE_RES_NOP;
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= '0;
            wreg_o         <= 1'b0;
            pc_o           <= '0;
            inst_invalid_o <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            wreg_o  <= 1'b0;
        end else if (w_accept) begin
            r_valid        <= 1'b1;
            aluop_o        <= w_aluop;
            alusel_o       <= w_alusel;
            reg1_o         <= w_op1;
            reg2_o         <= w_op2;
            wd_o           <= w_wd;
            wreg_o         <= w_wreg;
            pc_o           <= pc_i;
            inst_invalid_o <= w_inv;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (w_stall && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

endmodule
